// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 4-digit common-anode 7-segment scanner with tear-free frame updates
module seven_seg_scanner #(
    parameter int REFRESH_CNT = 100000,
    parameter int BLINK_CNT   = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  blank,
    input  logic [3:0]  blink,
    output logic        updated,
    output logic [3:0]  DIGIT,
    output logic [6:0]  DISPLAY
);

    localparam int RW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]    scan_idx_q, scan_idx_d;
    logic [15:0]   disp_value_q, disp_value_d;
    logic [3:0]    disp_blank_q, disp_blank_d;
    logic [3:0]    disp_blink_q, disp_blink_d;
    logic [15:0]   pend_value_q, pend_value_d;
    logic [3:0]    pend_blank_q, pend_blank_d;
    logic [3:0]    pend_blink_q, pend_blink_d;
    logic          pend_flag_q, pend_flag_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic          updated_q, updated_d;
    logic [3:0]    digit_q, digit_d;
    logic [6:0]    display_q, display_d;

    logic          refresh_tick;
    logic          frame_boundary;
    logic          apply_pending;
    logic          blink_wrap;
    logic [15:0]   value_shifted;
    logic [3:0]    slot_nibble;
    logic          slot_dark;

    // Hex nibble to active-low segments, ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Next-state: scan timing, frame-boundary handoff of pending data, blink phase, and output pattern
    always_comb begin
        refresh_tick   = (refresh_cnt_q == RW'(REFRESH_CNT - 1));
        refresh_cnt_d  = refresh_tick ? '0 : refresh_cnt_q + RW'(1);
        scan_idx_d     = refresh_tick ? scan_idx_q + 2'd1 : scan_idx_q;
        frame_boundary = refresh_tick && (scan_idx_q == 2'd3);
        apply_pending  = frame_boundary && pend_flag_q;

        disp_value_d = disp_value_q;
        disp_blank_d = disp_blank_q;
        disp_blink_d = disp_blink_q;
        if (apply_pending) begin
            disp_value_d = pend_value_q;
            disp_blank_d = pend_blank_q;
            disp_blink_d = pend_blink_q;
        end

        // A load on the boundary cycle is captured after the old pending set is consumed
        pend_value_d = load ? value : pend_value_q;
        pend_blank_d = load ? blank : pend_blank_q;
        pend_blink_d = load ? blink : pend_blink_q;
        pend_flag_d  = load | (pend_flag_q & ~apply_pending);
        updated_d    = apply_pending;

        blink_wrap    = (blink_cnt_q == BW'(BLINK_CNT - 1));
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q ^ blink_wrap;

        // Outputs are built from next-state values so they line up with the new index on the same edge
        value_shifted = disp_value_d >> {scan_idx_d, 2'b00};
        slot_nibble   = value_shifted[3:0];
        slot_dark     = disp_blank_d[scan_idx_d] | (disp_blink_d[scan_idx_d] & blink_phase_d);
        digit_d       = slot_dark ? 4'b1111 : ~(4'b0001 << scan_idx_d);
        display_d     = slot_dark ? 7'b1111111 : seg_decode(slot_nibble);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_q <= '0;
            scan_idx_q    <= 2'd0;
            disp_value_q  <= 16'h0000;
            disp_blank_q  <= 4'b0000;
            disp_blink_q  <= 4'b0000;
            pend_value_q  <= 16'h0000;
            pend_blank_q  <= 4'b0000;
            pend_blink_q  <= 4'b0000;
            pend_flag_q   <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            updated_q     <= 1'b0;
            digit_q       <= 4'b1110;
            display_q     <= 7'b1000000;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            scan_idx_q    <= scan_idx_d;
            disp_value_q  <= disp_value_d;
            disp_blank_q  <= disp_blank_d;
            disp_blink_q  <= disp_blink_d;
            pend_value_q  <= pend_value_d;
            pend_blank_q  <= pend_blank_d;
            pend_blink_q  <= pend_blink_d;
            pend_flag_q   <= pend_flag_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            updated_q     <= updated_d;
            digit_q       <= digit_d;
            display_q     <= display_d;
        end
    end

    assign updated = updated_q;
    assign DIGIT   = digit_q;
    assign DISPLAY = display_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - randomized model-checked bench for seven_seg_scanner
module tb_seven_seg_scanner;

    localparam int R = 4;
    localparam int B = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  blank = 4'b0000;
    logic [3:0]  blink = 4'b0000;
    logic        updated;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;

    seven_seg_scanner #(.REFRESH_CNT(R), .BLINK_CNT(B)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank(blank),
        .blink(blink), .updated(updated), .DIGIT(DIGIT), .DISPLAY(DISPLAY)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Model: n = clock edges since the last reset edge; everything else follows from arithmetic on n
    bit          m_valid = 1'b0;
    int          n = 0;
    logic [15:0] m_dval, m_pval;
    logic [3:0]  m_dblank, m_dblink, m_pblank, m_pblink;
    bit          m_pflag, m_upd;
    int          e_idx;
    bit          e_dark;
    logic [3:0]  e_digit;
    logic [6:0]  e_display;
    logic [15:0] e_shift;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            n = 0; m_valid = 1'b1;
            m_dval = 16'h0; m_dblank = 4'h0; m_dblink = 4'h0;
            m_pval = 16'h0; m_pblank = 4'h0; m_pblink = 4'h0;
            m_pflag = 1'b0; m_upd = 1'b0;
        end else if (m_valid) begin
            n++;
            m_upd = 1'b0;
            if ((n % (4 * R)) == 0 && m_pflag) begin
                m_dval = m_pval; m_dblank = m_pblank; m_dblink = m_pblink;
                m_pflag = 1'b0; m_upd = 1'b1;
            end
            if (load) begin
                m_pval = value; m_pblank = blank; m_pblink = blink; m_pflag = 1'b1;
            end
        end
        #1;
        if (m_valid) begin
            e_idx     = (n / R) % 4;
            e_dark    = m_dblank[e_idx] || (m_dblink[e_idx] && (((n / B) % 2) == 1));
            e_shift   = m_dval >> (4 * e_idx);
            e_digit   = e_dark ? 4'b1111 : ~(4'b0001 << e_idx);
            e_display = e_dark ? 7'b1111111 : seg[e_shift[3:0]];
            check("model_digit", {28'h0, DIGIT}, {28'h0, e_digit});
            check("model_display", {25'h0, DISPLAY}, {25'h0, e_display});
            check("model_updated", {31'h0, updated}, {31'h0, m_upd});
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] bl, input logic [3:0] bk);
        value = v; blank = bl; blink = bk; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int modulus, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((n % modulus) == target) return;
            @(negedge clk);
        end
        check("wait_phase_timeout", 0, 1);
    endtask

    task automatic wait_upd();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (updated) return;
        end
        check("updated_timeout", 0, 1);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (updated) pulses++;
        end
    endtask

    int pulses;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_digit", {28'h0, DIGIT}, 32'hE);
        check("reset_display", {25'h0, DISPLAY}, 32'h40);
        check("reset_updated", {31'h0, updated}, 32'h0);
        repeat (4) @(negedge clk);
        check("digit1_after_4", {28'h0, DIGIT}, 32'hD);
        repeat (12) @(negedge clk);
        check("digit0_after_16", {28'h0, DIGIT}, 32'hE);

        // 12AF loaded mid-frame appears only at the boundary
        wait_phase(16, R, 40);
        do_load(16'h12AF, 4'b0000, 4'b0000);
        check("hold_until_boundary", {25'h0, DISPLAY}, 32'h40);
        wait_upd();
        check("slot0_F", {25'h0, DISPLAY}, 32'b0001110);
        check("slot0_digit", {28'h0, DIGIT}, 32'hE);
        @(negedge clk);
        check("updated_one_cycle", {31'h0, updated}, 32'h0);
        repeat (R - 1) @(negedge clk);
        check("slot1_A", {25'h0, DISPLAY}, 32'b0001000);
        check("slot1_digit", {28'h0, DIGIT}, 32'hD);
        repeat (R) @(negedge clk);
        check("slot2_2", {25'h0, DISPLAY}, 32'b0100100);
        repeat (R) @(negedge clk);
        check("slot3_1", {25'h0, DISPLAY}, 32'b1111001);
        check("slot3_digit", {28'h0, DIGIT}, 32'h7);

        // Two loads in one frame: latest wins, one pulse
        wait_phase(16, 2, 40);
        do_load(16'h1111, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        do_load(16'h2222, 4'b0000, 4'b0000);
        wait_upd();
        check("latest_wins", {25'h0, DISPLAY}, 32'b0100100);
        count_pulses(20, pulses);
        check("single_pulse", pulses, 0);

        // Load on the boundary cycle
        wait_phase(16, 4, 40);
        do_load(16'hAAAA, 4'b0000, 4'b0000);
        wait_phase(16, 15, 40);
        do_load(16'hBBBB, 4'b0000, 4'b0000);
        check("boundary_pulse_1", {31'h0, updated}, 32'h1);
        check("boundary_shows_A", {25'h0, DISPLAY}, 32'b0001000);
        wait_upd();
        check("next_boundary_b", {25'h0, DISPLAY}, 32'b0000011);

        // Blank beats blink on slot 2; slot 0 blinks
        do_load(16'h8888, 4'b0100, 4'b0101);
        wait_upd();
        wait_phase(16, 2 * R + 1, 40);
        check("blank_digit", {28'h0, DIGIT}, 32'hF);
        check("blank_display", {25'h0, DISPLAY}, 32'h7F);
        wait_phase(128, 1, 200);
        check("blink_lit", {28'h0, DIGIT}, 32'hE);
        wait_phase(128, 65, 200);
        check("blink_dark", {28'h0, DIGIT}, 32'hF);
        check("blink_dark_seg", {25'h0, DISPLAY}, 32'h7F);

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 3000; i++) begin
            value = 16'($urandom);
            blank = 4'($urandom);
            blink = 4'($urandom);
            load  = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        load = 1'b0; rst = 1'b0;

        // Reset with pending data discards it
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_phase(16, 5, 40);
        do_load(16'h5555, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_digit", {28'h0, DIGIT}, 32'hE);
        check("midreset_display", {25'h0, DISPLAY}, 32'h40);
        check("midreset_updated", {31'h0, updated}, 32'h0);
        count_pulses(40, pulses);
        check("no_pulse_after_reset", pulses, 0);
        check("display_stays_0", {25'h0, DISPLAY}, 32'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
